// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared definitions for the crossbar_rr slice.
//   - bus command encodings
//   - arbiter FSM state type
//   - clog2 / index-width helpers used to size master-index and slave-select fields
package crossbar_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Ceiling log2, valid for value >= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++) begin
         if ((1 << b) < value) r = b + 1;
      end
      return r;
   endfunction

   // Width of an index into n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

   localparam int NM_DEFAULT  = 4;
   localparam int NS_DEFAULT  = 4;
   localparam int MIW_DEFAULT = idx_width(NM_DEFAULT);   // master-index width
   localparam int SSW_DEFAULT = idx_width(NS_DEFAULT);   // slave-select width

endpackage

// File: rtl/crossbar_rr_arbiter.sv
// crossbar_rr_arbiter: per-slave arbiter with IDLE/BUSY locking.
//
// Optional build macro CROSSBAR_FIXED_PRIO_EN: lowest eligible master index
// wins and the round-robin pointer is not built. Otherwise the search starts
// at the pointer and wraps.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   elig         per-master eligibility for this slave (used in IDLE)
//   req          raw master requests (used to detect owner drop in BUSY)
//   ack          slave acknowledge
//   gnt          one-hot grant (combinational)
//   gnt_valid    a master is being driven to the slave this cycle
//   gnt_idx      index of the granted master
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | search eligible masters, present winner the same cycle
// ST_BUSY | winner was not acked, keep driving the latched owner
module crossbar_rr_arbiter
   import crossbar_pkg::*;
#(
   parameter int NM  = 4,
   parameter int MIW = idx_width(NM)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NM-1:0]  elig,
   input  logic [NM-1:0]  req,
   input  logic           ack,
   output logic [NM-1:0]  gnt,
   output logic           gnt_valid,
   output logic [MIW-1:0] gnt_idx
);

   arb_state_t     state;
   logic [MIW-1:0] owner;
   logic [MIW-1:0] search_idx;
   logic           search_found;
   int             cand;

`ifndef CROSSBAR_FIXED_PRIO_EN
   logic [MIW-1:0] ptr;
   logic [MIW-1:0] next_ptr;
`endif

   always_comb begin
      search_found = 1'b0;
      search_idx   = '0;
      cand         = 0;
      for (int k = 0; k < NM; k++) begin
`ifdef CROSSBAR_FIXED_PRIO_EN
         cand = k;
`else
         cand = int'(ptr) + k;
         if (cand >= NM) cand = cand - NM;
`endif
         if (!search_found && elig[cand[MIW-1:0]]) begin
            search_found = 1'b1;
            search_idx   = cand[MIW-1:0];
         end
      end
   end

   // Grant is gated by reset so every slave-side output is quiet while reset is held.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = search_idx;
      if (!reset) begin
         if (state == ST_IDLE) begin
            gnt_valid = search_found;
         end else begin
            gnt_idx   = owner;
            gnt_valid = req[owner];
         end
      end
      gnt = '0;
      if (gnt_valid) gnt[gnt_idx] = 1'b1;
   end

`ifndef CROSSBAR_FIXED_PRIO_EN
   assign next_ptr = (gnt_idx == MIW'(NM - 1)) ? '0 : gnt_idx + MIW'(1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         owner <= '0;
`ifndef CROSSBAR_FIXED_PRIO_EN
         ptr   <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_valid) begin
                  if (ack) begin
`ifndef CROSSBAR_FIXED_PRIO_EN
                     ptr <= next_ptr;
`endif
                  end else begin
                     owner <= gnt_idx;
                     state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               // Owner abandoning its request is a protocol violation; release without
               // moving the pointer so nobody is skipped.
               if (!req[owner]) begin
                  state <= ST_IDLE;
               end else if (ack) begin
`ifndef CROSSBAR_FIXED_PRIO_EN
                  ptr <= next_ptr;
`endif
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/crossbar_rr.sv
// crossbar_rr: NM-master by NS-slave crossbar, one arbiter per slave so
// transfers to different slaves proceed concurrently. Each slave keeps a FIFO
// of master indices for outstanding reads so responses route back in order.
//
// Optional build macro CROSSBAR_FIXED_PRIO_EN selects fixed-priority
// arbitration in every slave arbiter (see crossbar_rr_arbiter).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   master_req/ack/cmd          per-master handshake, cmd 0 read / 1 write
//   master_addr/wdata           packed, master i at [i*W +: W]
//   master_resp/rdata           read data return, rdata zero when resp low
//   slave_req/ack/cmd           per-slave handshake
//   slave_addr/wdata            packed, zero when slave_req low
//   slave_resp/rdata            read data from slaves
// Slave select is addr[AW-1 -: log2(NS)].
module crossbar_rr
   import crossbar_pkg::*;
#(
   parameter int NM       = 4,
   parameter int NS       = 4,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RD_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NM-1:0]    master_req,
   output logic [NM-1:0]    master_ack,
   input  logic [NM-1:0]    master_cmd,
   input  logic [NM*AW-1:0] master_addr,
   input  logic [NM*DW-1:0] master_wdata,
   output logic [NM-1:0]    master_resp,
   output logic [NM*DW-1:0] master_rdata,
   output logic [NS-1:0]    slave_req,
   input  logic [NS-1:0]    slave_ack,
   output logic [NS-1:0]    slave_cmd,
   output logic [NS*AW-1:0] slave_addr,
   output logic [NS*DW-1:0] slave_wdata,
   input  logic [NS-1:0]    slave_resp,
   input  logic [NS*DW-1:0] slave_rdata
);

   localparam int MIW = idx_width(NM);
   localparam int SSW = clog2(NS);
   localparam int FAW = clog2(RD_DEPTH);
   localparam int CW  = clog2(RD_DEPTH + 1);
   localparam logic [FAW:0] PTR_ONE = (FAW + 1)'(1);
   localparam logic [FAW:0] PTR_FULL = (FAW + 1)'(RD_DEPTH);

   logic [SSW-1:0] sel     [NM];
   logic [NM-1:0]  elig    [NS];
   logic [NM-1:0]  gnt     [NS];
   logic [MIW-1:0] gnt_idx [NS];
   logic [NS-1:0]  gnt_valid;

   logic [MIW-1:0] fifo_mem [NS][RD_DEPTH];
   logic [FAW:0]   wr_ptr   [NS];
   logic [FAW:0]   rd_ptr   [NS];
   logic [MIW-1:0] head     [NS];
   logic [NS-1:0]  full;
   logic [NS-1:0]  empty;
   logic [NS-1:0]  push;
   logic [NS-1:0]  pop;

   logic [CW-1:0]  cnt [NM];
   logic [SSW-1:0] tgt [NM];
   logic [NM-1:0]  inc;
   logic [NM-1:0]  dec;

   always_comb begin
      for (int i = 0; i < NM; i++) begin
         sel[i] = master_addr[i*AW + AW - 1 -: SSW];
      end
   end

   always_comb begin
      for (int s = 0; s < NS; s++) begin
         full[s]  = ((wr_ptr[s] - rd_ptr[s]) == PTR_FULL);
         empty[s] = (wr_ptr[s] == rd_ptr[s]);
         head[s]  = fifo_mem[s][rd_ptr[s][FAW-1:0]];
      end
   end

   // A master with reads in flight may only talk to the slave holding them,
   // which keeps its responses strictly ordered and never simultaneous.
   always_comb begin
      for (int s = 0; s < NS; s++) begin
         elig[s] = '0;
         for (int i = 0; i < NM; i++) begin
            elig[s][i] = master_req[i]
                       && (sel[i] == SSW'(s))
                       && ((master_cmd[i] == CMD_WRITE) || !full[s])
                       && ((cnt[i] == '0) || (tgt[i] == SSW'(s)));
         end
      end
   end

   for (genvar gs = 0; gs < NS; gs++) begin : g_arb
      crossbar_rr_arbiter #(
         .NM  (NM),
         .MIW (MIW)
      ) u_arb (
         .clk       (clk),
         .reset     (reset),
         .elig      (elig[gs]),
         .req       (master_req),
         .ack       (slave_ack[gs]),
         .gnt       (gnt[gs]),
         .gnt_valid (gnt_valid[gs]),
         .gnt_idx   (gnt_idx[gs])
      );
   end

   always_comb begin
      slave_req   = gnt_valid;
      slave_cmd   = '0;
      slave_addr  = '0;
      slave_wdata = '0;
      for (int s = 0; s < NS; s++) begin
         if (gnt_valid[s]) begin
            slave_cmd[s]            = master_cmd[gnt_idx[s]];
            slave_addr[s*AW +: AW]  = master_addr[int'(gnt_idx[s])*AW +: AW];
            slave_wdata[s*DW +: DW] = master_wdata[int'(gnt_idx[s])*DW +: DW];
         end
      end
   end

   always_comb begin
      master_ack = '0;
      for (int s = 0; s < NS; s++) begin
         for (int i = 0; i < NM; i++) begin
            master_ack[i] = master_ack[i] | (gnt[s][i] & slave_ack[s]);
         end
      end
   end

   always_comb begin
      push = '0;
      pop  = '0;
      for (int s = 0; s < NS; s++) begin
         push[s] = gnt_valid[s] && slave_ack[s] && (slave_cmd[s] == CMD_READ);
         pop[s]  = slave_resp[s] && !empty[s] && !reset;
      end
   end

   always_comb begin
      master_resp  = '0;
      master_rdata = '0;
      inc          = '0;
      dec          = '0;
      for (int s = 0; s < NS; s++) begin
         if (pop[s]) begin
            master_resp[head[s]] = 1'b1;
            master_rdata[int'(head[s])*DW +: DW] = master_rdata[int'(head[s])*DW +: DW]
                                                 | slave_rdata[s*DW +: DW];
            dec[head[s]] = 1'b1;
         end
         if (push[s]) inc[gnt_idx[s]] = 1'b1;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NS; s++) begin
         if (push[s]) fifo_mem[s][wr_ptr[s][FAW-1:0]] <= gnt_idx[s];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < NS; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
         end
         for (int i = 0; i < NM; i++) begin
            cnt[i] <= '0;
            tgt[i] <= '0;
         end
      end else begin
         for (int s = 0; s < NS; s++) begin
            if (push[s]) begin
               wr_ptr[s]          <= wr_ptr[s] + PTR_ONE;
               tgt[gnt_idx[s]]    <= SSW'(s);
            end
            if (pop[s]) rd_ptr[s] <= rd_ptr[s] + PTR_ONE;
         end
         for (int i = 0; i < NM; i++) begin
            cnt[i] <= cnt[i] + CW'(inc[i]) - CW'(dec[i]);
         end
      end
   end

endmodule

// File: tb/tb_crossbar_rr.sv
module tb_crossbar_rr;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int RD_DEPTH = 4;

   logic             clk;
   logic             reset;
   logic [NM-1:0]    master_req;
   logic [NM-1:0]    master_ack;
   logic [NM-1:0]    master_cmd;
   logic [NM*AW-1:0] master_addr;
   logic [NM*DW-1:0] master_wdata;
   logic [NM-1:0]    master_resp;
   logic [NM*DW-1:0] master_rdata;
   logic [NS-1:0]    slave_req;
   logic [NS-1:0]    slave_ack;
   logic [NS-1:0]    slave_cmd;
   logic [NS*AW-1:0] slave_addr;
   logic [NS*DW-1:0] slave_wdata;
   logic [NS-1:0]    slave_resp;
   logic [NS*DW-1:0] slave_rdata;

   int n_cmp;
   int n_err;

   crossbar_rr #(
      .NM       (NM),
      .NS       (NS),
      .AW       (AW),
      .DW       (DW),
      .RD_DEPTH (RD_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .master_req   (master_req),
      .master_ack   (master_ack),
      .master_cmd   (master_cmd),
      .master_addr  (master_addr),
      .master_wdata (master_wdata),
      .master_resp  (master_resp),
      .master_rdata (master_rdata),
      .slave_req    (slave_req),
      .slave_ack    (slave_ack),
      .slave_cmd    (slave_cmd),
      .slave_addr   (slave_addr),
      .slave_wdata  (slave_wdata),
      .slave_resp   (slave_resp),
      .slave_rdata  (slave_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   req;
      logic [3:0]   cmd;
      logic [7:0]   sel;
      logic [3:0]   sack;
      logic [3:0]   sresp;
      logic [3:0]   exp_mack;
      logic [3:0]   exp_sreq;
      logic [3:0]   exp_mresp;
      logic [127:0] exp_rdata;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic [3:0] req, input logic [3:0] cmd,
                               input logic [7:0] sel, input logic [3:0] sack,
                               input logic [3:0] sresp, input logic [3:0] emack,
                               input logic [3:0] esreq, input logic [3:0] emresp,
                               input logic [127:0] erd);
      vec_t v;
      v.req = req; v.cmd = cmd; v.sel = sel; v.sack = sack; v.sresp = sresp;
      v.exp_mack = emack; v.exp_sreq = esreq; v.exp_mresp = emresp; v.exp_rdata = erd;
      return v;
   endfunction

   function automatic logic [31:0] addr_of(input int i, input int s);
      logic [29:0] low;
      low = 30'(32'h1000 + i * 32'h100);
      return {2'(s), low};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_m(input int i, input logic r, input logic c, input logic [1:0] s);
      master_req[i]          = r;
      master_cmd[i]          = c;
      master_addr[i*32 +: 32]  = addr_of(i, int'(s));
      master_wdata[i*32 +: 32] = 32'hA000_0000 + 32'(i);
   endtask

   task automatic idle_all();
      for (int i = 0; i < NM; i++) drive_m(i, 1'b0, 1'b0, 2'd0);
      slave_ack  = '0;
      slave_resp = '0;
   endtask

   task automatic default_rdata();
      for (int s = 0; s < NS; s++) slave_rdata[s*32 +: 32] = 32'hD000_0000 + 32'(s);
   endtask

   logic [3:0] wr_grant [5];

   initial begin
      n_cmp = 0;
      n_err = 0;
`ifdef CROSSBAR_FIXED_PRIO_EN
      wr_grant[0] = 4'b0001; wr_grant[1] = 4'b0001; wr_grant[2] = 4'b0001;
      wr_grant[3] = 4'b0001; wr_grant[4] = 4'b0001;
`else
      wr_grant[0] = 4'b0001; wr_grant[1] = 4'b0010; wr_grant[2] = 4'b0100;
      wr_grant[3] = 4'b1000; wr_grant[4] = 4'b0001;
`endif
      // m0 reads slave 1 and m2 reads slave 3 together, then both respond.
      vecs[0] = mk(4'b0101, 4'b0000, {2'd0, 2'd3, 2'd0, 2'd1}, 4'b1111, 4'b0000,
                   4'b0101, 4'b1010, 4'b0000, 128'h0);
      vecs[1] = mk(4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b1010,
                   4'b0000, 4'b0000, 4'b0101,
                   {32'h0, 32'hD000_0003, 32'h0, 32'hD000_0001});
      for (int k = 0; k < 5; k++) begin
         vecs[2+k] = mk(4'b1111, 4'b1111, 8'h00, 4'b1111, 4'b0000,
                        wr_grant[k], 4'b0001, 4'b0000, 128'h0);
      end

      reset = 1'b1;
      idle_all();
      default_rdata();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mack",   128'(master_ack),   128'h0);
      chk("rst_sreq",   128'(slave_req),    128'h0);
      chk("rst_mresp",  128'(master_resp),  128'h0);
      chk("rst_saddr",  128'(slave_addr),   128'h0);
      chk("rst_mrdata", 128'(master_rdata), 128'h0);

      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         for (int i = 0; i < NM; i++) drive_m(i, vecs[v].req[i], vecs[v].cmd[i], vecs[v].sel[2*i +: 2]);
         slave_ack  = vecs[v].sack;
         slave_resp = vecs[v].sresp;
         #1;
         chk($sformatf("vec%0d_mack", v),  128'(master_ack),  128'(vecs[v].exp_mack));
         chk($sformatf("vec%0d_sreq", v),  128'(slave_req),   128'(vecs[v].exp_sreq));
         chk($sformatf("vec%0d_mresp", v), 128'(master_resp), 128'(vecs[v].exp_mresp));
         chk($sformatf("vec%0d_rdata", v), 128'(master_rdata), vecs[v].exp_rdata);
      end

      // FIFO full at slave 2: four reads from m1, fifth held, write from m3 still served.
      @(negedge clk);
      idle_all();
      slave_ack = 4'b1111;
      drive_m(1, 1'b1, 1'b0, 2'd2);
      #1;
      chk("full_rd0_ack", 128'(master_ack), 128'h2);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("full_rd%0d_ack", k), 128'(master_ack), 128'h2);
      end
      @(negedge clk);
      #1;
      chk("full_hold_sreq", 128'(slave_req),  128'h0);
      chk("full_hold_mack", 128'(master_ack), 128'h0);
      @(negedge clk);
      drive_m(3, 1'b1, 1'b1, 2'd2);
      #1;
      chk("full_wr_mack",  128'(master_ack),            128'h8);
      chk("full_wr_saddr", 128'(slave_addr[2*32 +: 32]), 128'(addr_of(3, 2)));
      chk("full_wr_scmd",  128'(slave_cmd),             128'h4);
      @(negedge clk);
      drive_m(3, 1'b0, 1'b0, 2'd0);
      slave_resp = 4'b0100;
      #1;
      chk("full_pop_mresp", 128'(master_resp),          128'h2);
      chk("full_pop_rdata", 128'(master_rdata[63:32]),  128'hD000_0002);
      chk("full_pop_sreq",  128'(slave_req),            128'h0);
      @(negedge clk);
      slave_resp = 4'b0000;
      #1;
      chk("full_5th_sreq", 128'(slave_req),  128'h4);
      chk("full_5th_mack", 128'(master_ack), 128'h2);
      @(negedge clk);
      drive_m(1, 1'b0, 1'b0, 2'd0);
      slave_resp = 4'b0100;
      #1;
      chk("drain0_mresp", 128'(master_resp), 128'h2);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("drain%0d_mresp", k), 128'(master_resp), 128'h2);
      end
      @(negedge clk);
      #1;
      chk("empty_resp_ignored", 128'(master_resp), 128'h0);

      // m0 with a read outstanding at slave 1 may not start on slave 2.
      @(negedge clk);
      idle_all();
      slave_ack = 4'b1111;
      drive_m(0, 1'b1, 1'b0, 2'd1);
      #1;
      chk("tgt_rd1_mack", 128'(master_ack), 128'h1);
      chk("tgt_rd1_sreq", 128'(slave_req),  128'h2);
      @(negedge clk);
      drive_m(0, 1'b1, 1'b0, 2'd2);
      #1;
      chk("tgt_block0_sreq", 128'(slave_req),  128'h0);
      chk("tgt_block0_mack", 128'(master_ack), 128'h0);
      @(negedge clk);
      #1;
      chk("tgt_block1_sreq", 128'(slave_req), 128'h0);
      @(negedge clk);
      slave_resp = 4'b0010;
      slave_rdata[32 +: 32] = 32'hDEAD_BEEF;
      #1;
      chk("tgt_resp_mresp", 128'(master_resp),        128'h1);
      chk("tgt_resp_rdata", 128'(master_rdata[31:0]), 128'hDEAD_BEEF);
      chk("tgt_resp_sreq",  128'(slave_req),          128'h0);
      @(negedge clk);
      slave_resp = 4'b0000;
      default_rdata();
      #1;
      chk("tgt_go_sreq", 128'(slave_req),  128'h4);
      chk("tgt_go_mack", 128'(master_ack), 128'h1);
      @(negedge clk);
      drive_m(0, 1'b0, 1'b0, 2'd0);
      slave_resp = 4'b0100;
      #1;
      chk("tgt_drain_mresp", 128'(master_resp),        128'h1);
      chk("tgt_drain_rdata", 128'(master_rdata[31:0]), 128'hD000_0002);

      // Owner lock: slave 0 stalls three cycles, owner must not change.
      @(negedge clk);
      idle_all();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      slave_ack = 4'b0000;
      drive_m(0, 1'b1, 1'b1, 2'd0);
      drive_m(1, 1'b1, 1'b1, 2'd0);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         chk($sformatf("busy%0d_sreq", k),  128'(slave_req),          128'h1);
         chk($sformatf("busy%0d_saddr", k), 128'(slave_addr[31:0]),   128'(addr_of(0, 0)));
      end
      @(negedge clk);
      slave_ack = 4'b0001;
      #1;
      chk("busy_ack_mack",  128'(master_ack),        128'h1);
      chk("busy_ack_saddr", 128'(slave_addr[31:0]),  128'(addr_of(0, 0)));
      chk("busy_ack_wdata", 128'(slave_wdata[31:0]), 128'hA000_0000);
      @(negedge clk);
      drive_m(0, 1'b0, 1'b0, 2'd0);
      #1;
      chk("busy_next_mack",  128'(master_ack),       128'h2);
      chk("busy_next_saddr", 128'(slave_addr[31:0]), 128'(addr_of(1, 0)));

      // Reset with two reads pending at slave 3.
      @(negedge clk);
      idle_all();
      slave_ack = 4'b1111;
      drive_m(2, 1'b1, 1'b0, 2'd3);
      #1;
      chk("rst_rd0_mack", 128'(master_ack), 128'h4);
      @(negedge clk);
      #1;
      chk("rst_rd1_mack", 128'(master_ack), 128'h4);
      @(negedge clk);
      reset = 1'b1;
      slave_resp = 4'b1000;
      #1;
      chk("inrst_mack",   128'(master_ack),   128'h0);
      chk("inrst_sreq",   128'(slave_req),    128'h0);
      chk("inrst_mresp",  128'(master_resp),  128'h0);
      chk("inrst_saddr",  128'(slave_addr),   128'h0);
      chk("inrst_mrdata", 128'(master_rdata), 128'h0);
      @(negedge clk);
      reset = 1'b0;
      drive_m(2, 1'b0, 1'b0, 2'd0);
      slave_resp = 4'b1000;
      #1;
      chk("postrst_resp_dropped", 128'(master_resp), 128'h0);
      @(negedge clk);
      slave_resp = 4'b0000;
      drive_m(2, 1'b1, 1'b0, 2'd0);
      #1;
      chk("postrst_cnt_clear_mack", 128'(master_ack), 128'h4);
      @(negedge clk);
      idle_all();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
